mdu: RTL and testbench
======================

# mdu

Multiply/divide unit in the E stage of the P7 pipeline, downstream of the instruction controller. It consumes the controller's `MDU_op`, `md`, `mf` and `mt` decode for the E-stage instruction and owns the HI/LO registers. Multiply and divide run as multi-cycle operations, and `busy` tells the hazard unit when to stall dependent MDU instructions. `mfhi`/`mflo` data is returned combinationally for forwarding into the E-stage result mux.

## Interface
- `MULT_CYCLES`, 5, busy cycles for mult/multu (≥1)
- `DIV_CYCLES`, 10, busy cycles for div/divu (≥1)

- `clk` in 1, rising-edge clock
- `reset_n` in 1, asynchronous, active-low reset
- `MDU_op` in 3, from controller: 000 none, 001 mult, 010 multu, 011 div, 100 divu, 101 mthi, 110 mtlo, 111 reserved (no-op)
- `md` in 1, E-stage instruction is mult/multu/div/divu
- `mt` in 1, E-stage instruction is mthi/mtlo
- `mf_hi` in 1, mf read select: 1 = HI, 0 = LO
- `cancel` in 1, exception/interrupt taken this cycle; blocks any start or write
- `A` in 32, forwarded rs value
- `B` in 32, forwarded rt value
- `busy` out 1, multi-cycle op in flight
- `hi` out 32, architectural HI
- `lo` out 32, architectural LO
- `mf_data` out 32, `mf_hi ? hi : lo`, combinational

## Operation
- FSM: IDLE, RUN. Reset: IDLE, `busy`=0, `hi`=`lo`=0, counter=0, pending regs=0.
- IDLE, `md` && !`cancel`: latch the result of A op B into `pend_hi`/`pend_lo`. Load counter with MULT_CYCLES or DIV_CYCLES. Go to RUN.
- RUN: counter decrements each edge. On the edge where counter is 1, commit `pend_hi`→`hi` and `pend_lo`→`lo`, then return to IDLE.
- mult: signed 64-bit product {HI,LO}. multu: unsigned product.
- div/divu: LO=quotient, HI=remainder. Signed division truncates toward zero; the remainder takes the dividend's sign.
- Divide by zero (both signed and unsigned): HI=A, LO=32'hFFFF_FFFF.
- Signed overflow 32'h8000_0000 / 32'hFFFF_FFFF: LO=32'h8000_0000, HI=0.
- mthi/mtlo (`mt`, IDLE, !`cancel`): write A to HI/LO on the next edge. No busy cycle.
- `md`/`mt` while RUN is a hazard-unit error. The request is ignored, state is unchanged, and simulation flags an error.
- `cancel` blocks only a same-cycle start or write. An op already in RUN always completes.
- `MDU_op` 000/111, or an op disagreeing with `md`/`mt`: no effect.

## Timing
- A start sampled at edge t0 gives `busy`=1 from t0 through edge t0+N, where N is the latency. At edge t0+N, `hi`/`lo` update and `busy` falls.
- A back-to-back `md` may start in the first cycle `busy`=0.
- `mf_data` during RUN shows the old HI/LO. The hazard unit stalls `mf` while `busy` || `md`.
- mthi/mtlo: visible on `hi`/`lo` one cycle after the edge.
- `reset_n` low mid-RUN: immediate return to the reset state. The pending result is discarded.

## Configuration
- `MDU_BUSY_EN` defined: multi-cycle behaviour as above.
- `MDU_BUSY_EN` undefined: every md op commits at the start edge (latency 1). `busy` is tied to 0, the FSM stays in IDLE, and the parameters are unused. This build is for fast ISA-level simulation only.

## Structure
- `mdu_pkg`: MDU_op encodings (`MDU_NONE`…`MDU_MTLO`), default cycle counts, and the FSM state typedef.
- Sub-module `mdu_seq`: IDLE/RUN FSM plus down-counter. Inputs: start pulse and latency. Outputs: `busy` and a `commit` pulse. Datapath and HI/LO stay in `mdu`.

## Test plan
- mult, A=32'hFFFF_FFFE (−2), B=3 → `busy` high 5 cycles; then HI=32'hFFFF_FFFF, LO=32'hFFFF_FFFA.
- divu, A=100, B=7 → `busy` high 10 cycles; then LO=14, HI=2. div, A=−7, B=2 → LO=32'hFFFF_FFFD, HI=32'hFFFF_FFFF.
- div, A=5, B=0 → HI=5, LO=32'hFFFF_FFFF. div, A=32'h8000_0000, B=−1 → LO=32'h8000_0000, HI=0.
- mthi, A=32'h1234_5678 then mflo/mfhi → `hi` updates the next cycle, `busy` stays 0, and `mf_data` follows `mf_hi`.
- mult with `cancel`=1 on the start cycle → no busy, HI/LO unchanged. `cancel` asserted during RUN → result still commits on time.
- `reset_n` pulsed low at RUN cycle 3 of a divide → `busy`=0, HI=LO=0 immediately. A new mult then completes normally.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the E-stage multiply/divide unit: op encodings,
// default latencies, HI/LO result struct and sequencer state type.
package mdu_pkg;

   typedef enum logic [2:0] {
      MDU_NONE  = 3'b000,
      MDU_MULT  = 3'b001,
      MDU_MULTU = 3'b010,
      MDU_DIV   = 3'b011,
      MDU_DIVU  = 3'b100,
      MDU_MTHI  = 3'b101,
      MDU_MTLO  = 3'b110,
      MDU_RSVD  = 3'b111
   } mdu_op_e;

   localparam int MULT_CYCLES_DEF = 5;
   localparam int DIV_CYCLES_DEF  = 10;
   localparam int CNT_W           = 8;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } mdu_state_e;

   typedef struct packed {
      logic [31:0] hi;
      logic [31:0] lo;
   } hilo_t;

endpackage

// File: rtl/mdu_if.sv
// Controller-facing bundle of the MDU: decoded op, operands, HI/LO and stall status.
interface mdu_if;
   import mdu_pkg::*;

   mdu_op_e     MDU_op;
   logic        md;
   logic        mt;
   logic        mf_hi;
   logic        cancel;
   logic [31:0] A;
   logic [31:0] B;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;
   logic [31:0] mf_data;

   modport master (
      output MDU_op, md, mt, mf_hi, cancel, A, B,
      input  busy, hi, lo, mf_data
   );

   modport slave (
      input  MDU_op, md, mt, mf_hi, cancel, A, B,
      output busy, hi, lo, mf_data
   );
endinterface

// File: rtl/mdu_seq.sv
// IDLE/RUN sequencer for multi-cycle MDU ops: a down-counter loaded on start
// that raises commit on its final edge.
module mdu_seq
   import mdu_pkg::*;
(
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [CNT_W-1:0] latency,
   output logic             busy,
   output logic             commit
);

   mdu_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // NOTE: defaults first so no path through the case leaves a variable unassigned (no latches).
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      commit  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_RUN;
               cnt_d   = latency;
            end
         end
         ST_RUN: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q <= CNT_W'(1)) begin
               commit  = 1'b1;
               state_d = ST_IDLE;
               cnt_d   = '0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign busy = (state_q == ST_RUN);

endmodule

// File: rtl/mdu.sv
// E-stage multiply/divide unit owning HI/LO. Define MDU_BUSY_EN for multi-cycle
// latency; without it every md op commits at its start edge and busy stays 0.
module mdu
   import mdu_pkg::*;
#(
   parameter int MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
   input  logic clk,
   input  logic reset_n,
   mdu_if.slave bus
);

   logic               is_mult, is_md_op;
   logic               running, start, mthi_wr, mtlo_wr;
   logic               seq_start, seq_busy, seq_commit, direct_commit;
   logic [CNT_W-1:0]   latency;
   logic signed [63:0] a_ext, b_ext;
   hilo_t              result, pend, arch;

   always_comb begin
      is_mult  = (bus.MDU_op == MDU_MULT) || (bus.MDU_op == MDU_MULTU);
      is_md_op = is_mult || (bus.MDU_op == MDU_DIV) || (bus.MDU_op == MDU_DIVU);
   end

   assign running = seq_busy;
   assign start   = bus.md && is_md_op && !bus.cancel && !running;
   assign mthi_wr = bus.mt && (bus.MDU_op == MDU_MTHI) && !bus.cancel && !running;
   assign mtlo_wr = bus.mt && (bus.MDU_op == MDU_MTLO) && !bus.cancel && !running;
   assign latency = is_mult ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);

`ifdef MDU_BUSY_EN
   assign seq_start     = start;
   assign direct_commit = 1'b0;
   assign bus.busy      = seq_busy;
`else
   assign seq_start     = 1'b0;
   assign direct_commit = start;
   assign bus.busy      = 1'b0;
`endif

   mdu_seq u_seq (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (seq_start),
      .latency (latency),
      .busy    (seq_busy),
      .commit  (seq_commit)
   );

   // Zero divisor and the single signed-overflow case are resolved before the divider.
   always_comb begin
      a_ext  = {{32{bus.A[31]}}, bus.A};
      b_ext  = {{32{bus.B[31]}}, bus.B};
      result = '0;
      case (bus.MDU_op)
         MDU_MULT:  result = hilo_t'(a_ext * b_ext);
         MDU_MULTU: result = hilo_t'({32'b0, bus.A} * {32'b0, bus.B});
         MDU_DIV: begin
            if (bus.B == 32'h0) begin
               result = '{hi: bus.A, lo: 32'hFFFF_FFFF};
            end else if (bus.A == 32'h8000_0000 && bus.B == 32'hFFFF_FFFF) begin
               result = '{hi: 32'h0, lo: 32'h8000_0000};
            end else begin
               result.lo = 32'($signed(bus.A) / $signed(bus.B));
               result.hi = 32'($signed(bus.A) % $signed(bus.B));
            end
         end
         MDU_DIVU: begin
            if (bus.B == 32'h0) begin
               result = '{hi: bus.A, lo: 32'hFFFF_FFFF};
            end else begin
               result.lo = bus.A / bus.B;
               result.hi = bus.A % bus.B;
            end
         end
         default: result = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         arch <= '0;
         pend <= '0;
      end else begin
         if (start) pend <= result;
         if (seq_commit) begin
            arch <= pend;
         end else if (direct_commit) begin
            arch <= result;
         end else begin
            if (mthi_wr) arch.hi <= bus.A;
            if (mtlo_wr) arch.lo <= bus.A;
         end
      end
   end

   assign bus.hi      = arch.hi;
   assign bus.lo      = arch.lo;
   assign bus.mf_data = bus.mf_hi ? arch.hi : arch.lo;

   // The hazard unit must stall md/mt while an op is in flight.
   hazard_chk: assert property (@(posedge clk) disable iff (!reset_n)
                                !(running && (bus.md || bus.mt)));

endmodule

// File: tb/tb_mdu.sv
// Directed self-checking bench for mdu; expected latencies follow MDU_BUSY_EN.
`timescale 1ns/1ps
module tb_mdu;
   import mdu_pkg::*;

`ifdef MDU_BUSY_EN
   localparam bit BUSY_EN = 1'b1;
`else
   localparam bit BUSY_EN = 1'b0;
`endif
   localparam int MULT_N    = 5;
   localparam int DIV_N     = 10;
   localparam int MULT_BUSY = BUSY_EN ? MULT_N : 0;
   localparam int DIV_BUSY  = BUSY_EN ? DIV_N : 0;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   int          errors = 0;
   int          checks = 0;
   logic [31:0] exp_hi, exp_lo;

   mdu_if bus ();

   mdu #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      bus.MDU_op = MDU_NONE;
      bus.md     = 1'b0;
      bus.mt     = 1'b0;
      bus.cancel = 1'b0;
      bus.A      = 32'h0;
      bus.B      = 32'h0;
   endtask

   // Called at a negedge; returns at the first negedge with busy low.
   task automatic run_md(input string tag, input mdu_op_e op, input logic [31:0] a,
                         input logic [31:0] b, input logic cancel_start, input logic cancel_run,
                         input int exp_busy, input logic [31:0] new_hi, input logic [31:0] new_lo);
      int n;
      bus.MDU_op = op;
      bus.md     = 1'b1;
      bus.A      = a;
      bus.B      = b;
      bus.cancel = cancel_start;
      bus.mf_hi  = 1'b1;
      @(negedge clk);
      idle_inputs();
      bus.cancel = cancel_run;
      check({tag, " mf_data early"}, bus.mf_data, (exp_busy > 0) ? exp_hi : new_hi);
      n = 0;
      while (bus.busy === 1'b1 && n < 200) begin
         n++;
         @(negedge clk);
      end
      bus.cancel = 1'b0;
      check({tag, " busy cycles"}, 32'(n), 32'(exp_busy));
      exp_hi = new_hi;
      exp_lo = new_lo;
      check({tag, " hi"}, bus.hi, exp_hi);
      check({tag, " lo"}, bus.lo, exp_lo);
   endtask

   // Drives one cycle of raw decode, then checks that HI/LO match the model.
   task automatic poke(input string tag, input mdu_op_e op, input logic md, input logic mt,
                       input logic cancel, input logic [31:0] a);
      bus.MDU_op = op;
      bus.md     = md;
      bus.mt     = mt;
      bus.cancel = cancel;
      bus.A      = a;
      @(negedge clk);
      idle_inputs();
      check({tag, " busy"}, 32'(bus.busy), 32'h0);
      check({tag, " hi"}, bus.hi, exp_hi);
      check({tag, " lo"}, bus.lo, exp_lo);
   endtask

   initial begin
      idle_inputs();
      bus.mf_hi = 1'b0;
      exp_hi    = 32'h0;
      exp_lo    = 32'h0;
      reset_n   = 1'b0;
      repeat (2) @(negedge clk);
      check("reset busy", 32'(bus.busy), 32'h0);
      check("reset hi", bus.hi, 32'h0);
      check("reset lo", bus.lo, 32'h0);
      check("reset mf_data", bus.mf_data, 32'h0);
      reset_n = 1'b1;
      @(negedge clk);

      run_md("mult -2*3", MDU_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0, MULT_BUSY,
             32'hFFFF_FFFF, 32'hFFFF_FFFA);
      run_md("divu 100/7", MDU_DIVU, 32'd100, 32'd7, 1'b0, 1'b0, DIV_BUSY, 32'd2, 32'd14);
      run_md("div -7/2", MDU_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, DIV_BUSY,
             32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_md("div 7/-2", MDU_DIV, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0, DIV_BUSY,
             32'd1, 32'hFFFF_FFFD);
      run_md("divu big/2", MDU_DIVU, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, DIV_BUSY,
             32'd1, 32'h7FFF_FFFC);
      run_md("div 5/0", MDU_DIV, 32'd5, 32'd0, 1'b0, 1'b0, DIV_BUSY, 32'd5, 32'hFFFF_FFFF);
      run_md("divu 9/0", MDU_DIVU, 32'd9, 32'd0, 1'b0, 1'b0, DIV_BUSY, 32'd9, 32'hFFFF_FFFF);
      run_md("div ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, DIV_BUSY,
             32'h0, 32'h8000_0000);
      run_md("multu max", MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, MULT_BUSY,
             32'hFFFF_FFFE, 32'h0000_0001);

      // mthi/mtlo and the mf read mux
      bus.mf_hi = 1'b1;
      exp_hi    = 32'h1234_5678;
      poke("mthi", MDU_MTHI, 1'b0, 1'b1, 1'b0, 32'h1234_5678);
      check("mfhi data", bus.mf_data, 32'h1234_5678);
      bus.mf_hi = 1'b0;
      #1;
      check("mflo data", bus.mf_data, exp_lo);
      exp_lo = 32'hCAFE_F00D;
      poke("mtlo", MDU_MTLO, 1'b0, 1'b1, 1'b0, 32'hCAFE_F00D);
      check("mflo new", bus.mf_data, 32'hCAFE_F00D);

      // requests that must leave HI/LO alone
      poke("mthi cancel", MDU_MTHI, 1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF);
      poke("mthi no mt", MDU_MTHI, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF);
      poke("mt with mult op", MDU_MULT, 1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF);
      poke("md reserved op", MDU_RSVD, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF);

      run_md("mult cancel start", MDU_MULT, 32'd7, 32'd6, 1'b1, 1'b0, 0, exp_hi, exp_lo);
      run_md("mult cancel run", MDU_MULT, 32'd7, 32'd6, 1'b0, 1'b1, MULT_BUSY, 32'h0, 32'd42);

      // reset in the third RUN cycle of a divide
      bus.MDU_op = MDU_DIVU;
      bus.md     = 1'b1;
      bus.A      = 32'd100;
      bus.B      = 32'd7;
      @(negedge clk);
      idle_inputs();
      repeat (2) @(negedge clk);
      reset_n = 1'b0;
      #1;
      exp_hi = 32'h0;
      exp_lo = 32'h0;
      check("midrun reset busy", 32'(bus.busy), 32'h0);
      check("midrun reset hi", bus.hi, 32'h0);
      check("midrun reset lo", bus.lo, 32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      run_md("mult after reset", MDU_MULT, 32'd3, 32'd4, 1'b0, 1'b0, MULT_BUSY, 32'h0, 32'd12);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
